sensor_debouncer: RTL and testbench



---
 rtl/sensor_pkg.sv | 19 +
 rtl/debounce_channel.sv | 61 ++++++
 rtl/sensor_debouncer.sv | 94 +++++++++
 tb/tb_sensor_debouncer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants for the sensor input conditioning front end: channel count,
// channel indices and default debounce/synchronizer depths.
package sensor_pkg;

    localparam int unsigned NUM_SENSOR_CH = 6;

    localparam int unsigned CH_SENE   = 0;
    localparam int unsigned CH_SENF   = 1;
    localparam int unsigned CH_SEND   = 2;
    localparam int unsigned CH_SENA   = 3;
    localparam int unsigned CH_POWER  = 4;
    localparam int unsigned CH_BATERY = 5;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_SYNC_STAGES     = 2;

    typedef logic [NUM_SENSOR_CH-1:0] sensor_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchronizer chain, run counter, committed stable level
// and a one-cycle change strobe aligned with the first cycle of the new level.
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic change
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   change_q, change_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            change_q <= change_d;
        end
    end

    // Any cycle where synced agrees with stable restarts the run, so short
    // glitches never accumulate toward a commit.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        change_d = 1'b0;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = synced;
            cnt_d    = '0;
            change_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign stable = stable_q;
    assign change = change_q;

endmodule

// File: rtl/sensor_debouncer.sv
// Debounces the four obstacle sensors, power switch and battery line, and
// raises sensors_ready once the post-reset settling time has elapsed.
module sensor_debouncer
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_SenE,
    input  logic       raw_SenF,
    input  logic       raw_SenD,
    input  logic       raw_SenA,
    input  logic       raw_power_switch,
    input  logic       raw_batery_status,
    output logic       SenE,
    output logic       SenF,
    output logic       SenD,
    output logic       SenA,
    output logic       power_switch,
    output logic       batery_status,
    output logic [5:0] event_mask,
    output logic       sensor_event,
    output logic       sensors_ready
);

    localparam int unsigned READY_AT = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int unsigned SW       = $clog2(READY_AT + 1);

    sensor_vec_t raw_vec;
    sensor_vec_t clean_vec;
    sensor_vec_t change_vec;

    always_comb begin
        raw_vec            = '0;
        raw_vec[CH_SENE]   = raw_SenE;
        raw_vec[CH_SENF]   = raw_SenF;
        raw_vec[CH_SEND]   = raw_SenD;
        raw_vec[CH_SENA]   = raw_SenA;
        raw_vec[CH_POWER]  = raw_power_switch;
        raw_vec[CH_BATERY] = raw_batery_status;
    end

    for (genvar c = 0; c < NUM_SENSOR_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[c]),
            .stable(clean_vec[c]),
            .change(change_vec[c])
        );
    end

    assign SenE          = clean_vec[CH_SENE];
    assign SenF          = clean_vec[CH_SENF];
    assign SenD          = clean_vec[CH_SEND];
    assign SenA          = clean_vec[CH_SENA];
    assign power_switch  = clean_vec[CH_POWER];
    assign batery_status = clean_vec[CH_BATERY];
    assign event_mask    = change_vec;
    assign sensor_event  = |change_vec;

    // Startup counter saturates at READY_AT; ready is sticky until reset.
    logic [SW-1:0] start_q, start_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            ready_q <= 1'b0;
        end else begin
            start_q <= start_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        start_d = start_q;
        ready_d = ready_q;
        if (start_q != SW'(READY_AT)) begin
            start_d = start_q + SW'(1);
        end
        if (start_d == SW'(READY_AT)) begin
            ready_d = 1'b1;
        end
    end

    assign sensors_ready = ready_q;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Self-checking bench for sensor_debouncer: directed vector table, hand-written
// corner sequences and a randomized run against a sliding-window reference model.
module tb_sensor_debouncer;
    import sensor_pkg::*;

    localparam int D   = 4;
    localparam int S   = 2;
    localparam int LAT = S + D;
    localparam int NR  = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] raw;
    logic       SenE, SenF, SenD, SenA, power_switch, batery_status;
    logic [5:0] event_mask;
    logic       sensor_event, sensors_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sensor_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .raw_SenE         (raw[0]),
        .raw_SenF         (raw[1]),
        .raw_SenD         (raw[2]),
        .raw_SenA         (raw[3]),
        .raw_power_switch (raw[4]),
        .raw_batery_status(raw[5]),
        .SenE             (SenE),
        .SenF             (SenF),
        .SenD             (SenD),
        .SenA             (SenA),
        .power_switch     (power_switch),
        .batery_status    (batery_status),
        .event_mask       (event_mask),
        .sensor_event     (sensor_event),
        .sensors_ready    (sensors_ready)
    );

    typedef struct {
        logic [5:0] raw;
        logic [5:0] stable;
        logic [5:0] ev;
        logic       ready;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [5:0] stable_vec();
        return {batery_status, power_switch, SenA, SenD, SenF, SenE};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert mid-cycle, hold two edges, release away from the edge.
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_all(input string name, input logic [5:0] st, input logic [5:0] ev,
                             input logic rdy);
        check({name, ".stable"}, 8'(stable_vec()), 8'(st));
        check({name, ".event"}, 8'(event_mask), 8'(ev));
        check({name, ".sensor_event"}, 8'(sensor_event), 8'(|ev));
        check({name, ".ready"}, 8'(sensors_ready), 8'(rdy));
    endtask

    logic [5:0] hist[NR+1];
    int         last_commit[6];
    logic [5:0] mst;
    logic [5:0] mev;
    int         ev_cnt;
    logic       seen;

    initial begin
        // Test 1: all raw high through reset.
        raw   = 6'h3f;
        reset = 1'b1;
        #1;
        check_all("t1_in_reset", 6'h00, 6'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("t1_in_reset2", 6'h00, 6'h00, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_all($sformatf("t1_e%0d", e), (e >= LAT) ? 6'h3f : 6'h00,
                      (e == LAT) ? 6'h3f : 6'h00, e >= LAT);
        end

        // Test 5: async reset clears committed state at once.
        raw = 6'h10;
        #3;
        reset = 1'b1;
        #1;
        check_all("t5_async_clear", 6'h00, 6'h00, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        check("t5_mid_power", 8'(power_switch), 8'h0);
        check("t5_mid_ready", 8'(sensors_ready), 8'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_all($sformatf("t5_e%0d", e), (e >= LAT) ? 6'h10 : 6'h00,
                      (e == LAT) ? 6'h10 : 6'h00, e >= LAT);
        end

        // Tests 2 and 4 as a vector table from a clean reset.
        for (int i = 0; i < 14; i++) begin
            tbl[i].raw    = (i < 7) ? 6'h02 : 6'h0b;
            tbl[i].stable = (i < 5) ? 6'h00 : ((i < 12) ? 6'h02 : 6'h0b);
            tbl[i].ev     = (i == 5) ? 6'h02 : ((i == 12) ? 6'h09 : 6'h00);
            tbl[i].ready  = (i >= 5);
        end
        raw = 6'h00;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            raw = tbl[i].raw;
            tick();
            check_all($sformatf("tbl%0d", i), tbl[i].stable, tbl[i].ev, tbl[i].ready);
        end

        // Test 3: three-cycle pulse on SenD never commits.
        seen = 1'b0;
        raw  = 6'h0f;
        for (int e = 0; e < 13; e++) begin
            if (e == 3) raw = 6'h0b;
            tick();
            if (event_mask != 6'h00 || SenD) seen = 1'b1;
        end
        check("t3_no_commit", 8'(seen), 8'h0);
        check("t3_stable", 8'(stable_vec()), 8'h0b);

        // Test 6: battery toggling every 2 cycles, then held high.
        ev_cnt = 0;
        for (int seg = 0; seg < 10; seg++) begin
            raw[5] = (seg % 2 == 0);
            repeat (2) begin
                tick();
                if (event_mask[5]) ev_cnt++;
            end
        end
        raw[5] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (event_mask[5]) ev_cnt++;
            if (e == LAT - 1) check("t6_before", 8'(batery_status), 8'h0);
            if (e == LAT) check("t6_commit", 8'(batery_status), 8'h1);
        end
        check("t6_event_count", 8'(ev_cnt), 8'h1);

        // Randomized run: a commit happens at edge n iff no commit in the last D-1
        // edges and the D synced samples ending at n all differ from the stable level,
        // where the sample compared at edge n is the raw level taken at edge n-S.
        raw = 6'h00;
        apply_reset();
        mst = 6'h00;
        for (int c = 0; c < 6; c++) last_commit[c] = -1000;
        for (int n = 1; n <= NR; n++) begin
            for (int c = 0; c < 6; c++) begin
                if ($urandom_range(3) == 0) raw[c] = ~raw[c];
            end
            hist[n] = raw;
            tick();
            mev = 6'h00;
            for (int c = 0; c < 6; c++) begin
                logic ok;
                ok = (n - last_commit[c] >= D);
                for (int k = 0; k < D; k++) begin
                    int   idx;
                    logic sv;
                    idx = n - k - S;
                    sv  = (idx >= 1) ? hist[idx][c] : 1'b0;
                    if (sv == mst[c]) ok = 1'b0;
                end
                if (ok) begin
                    mev[c]         = 1'b1;
                    mst[c]         = ~mst[c];
                    last_commit[c] = n;
                end
            end
            check_all($sformatf("rnd%0d", n), mst, mev, n >= LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
